// File: rtl/ahb_dma_master_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_dma_master_pkg                                                   |
// | AHB encodings and helpers shared by the DMA master and its buffer.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ahb_dma_master_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  // A 4-beat word burst starting at this word index stays inside one 1KB page.
  function automatic logic incr4_fits(input logic [7:0] word_idx);
    return (word_idx <= 8'hFC);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_dma_master_word_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dma_word_buffer                                                      |
// | Staging register file between the read and write bursts of a chunk. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module dma_word_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [31:0] push_data_i,
  input  logic        pop_i,
  output logic [31:0] pop_data_o
);

  localparam int PW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;

  // Words are written in read-beat order and handed out in the same order.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/ahb_dma_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_dma_master                                                       |
// | Single-channel AHB memory-to-memory copy engine, INCR4 or SINGLE.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ahb_dma_master
  import ahb_dma_master_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int BUF_DEPTH = 4
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [2:0]       HBURST,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic [1:0]       HRESP,
  input  logic [31:0]      HRDATA
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CHK    = 3'd1;
  localparam logic [2:0] ST_RD     = 3'd2;
  localparam logic [2:0] ST_RD_END = 3'd3;
  localparam logic [2:0] ST_WR     = 3'd4;
  localparam logic [2:0] ST_WR_END = 3'd5;
  localparam logic [2:0] ST_ABORT  = 3'd6;
  localparam logic [2:0] ST_FIN    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_CHK    = ST_CHK,
    S_RD     = ST_RD,
    S_RD_END = ST_RD_END,
    S_WR     = ST_WR,
    S_WR_END = ST_WR_END,
    S_ABORT  = ST_ABORT,
    S_FIN    = ST_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             chunk4_q, chunk4_d;
  logic [1:0]       abeat_q, abeat_d;
  logic             dphase_q, dphase_d;
  logic             err_q, err_d;
  logic [31:0]      haddr_q, haddr_d;
  logic [1:0]       htrans_q, htrans_d;
  logic             hwrite_q, hwrite_d;
  logic [2:0]       hburst_q, hburst_d;
  logic [31:0]      hwdata_q, hwdata_d;
  logic             w_buf_clear;

  logic        w_addr_acc, w_data_err, w_data_ok, w_push, w_pop;
  logic        w_last_beat, w_misaligned, w_chunk4;
  logic [31:0] w_buf_rdata, w_step;

  // A data phase is pending after any accepted address phase; an ERROR response
  // is acted on in its first cycle so the following address can be withdrawn.
  assign w_addr_acc   = (htrans_q != HTRANS_IDLE) && HREADY;
  assign w_data_err   = dphase_q && (HRESP != HRESP_OKAY);
  assign w_data_ok    = dphase_q && HREADY && (HRESP == HRESP_OKAY);
  assign w_push       = w_data_ok && ((state_q == S_RD) || (state_q == S_RD_END));
  assign w_pop        = w_addr_acc && hwrite_q && (state_q == S_WR);
  assign w_last_beat  = (abeat_q == (chunk4_q ? 2'd3 : 2'd0));
  assign w_misaligned = (src_q[1:0] != 2'b00) || (dst_q[1:0] != 2'b00);
  assign w_chunk4     = (rem_q >= LEN_W'(4)) && incr4_fits(src_q[9:2]) && incr4_fits(dst_q[9:2]);
  assign w_step       = chunk4_q ? 32'd16 : 32'd4;

  dma_word_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .clear_i    (w_buf_clear),
    .push_i     (w_push),
    .push_data_i(HRDATA),
    .pop_i      (w_pop),
    .pop_data_o (w_buf_rdata)
  );

  // State and bus-output registers; bus outputs only move on accepted phases.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      rem_q    <= '0;
      chunk4_q <= 1'b0;
      abeat_q  <= '0;
      dphase_q <= 1'b0;
      err_q    <= 1'b0;
      haddr_q  <= '0;
      htrans_q <= HTRANS_IDLE;
      hwrite_q <= 1'b0;
      hburst_q <= HBURST_SINGLE;
      hwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      rem_q    <= rem_d;
      chunk4_q <= chunk4_d;
      abeat_q  <= abeat_d;
      dphase_q <= dphase_d;
      err_q    <= err_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      hburst_q <= hburst_d;
      hwdata_q <= hwdata_d;
    end
  end

  // Next-state logic: chunk sizing, burst sequencing, error abort.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    chunk4_d    = chunk4_q;
    abeat_d     = abeat_q;
    err_d       = err_q;
    haddr_d     = haddr_q;
    htrans_d    = htrans_q;
    hwrite_d    = hwrite_q;
    hburst_d    = hburst_q;
    hwdata_d    = hwdata_q;
    w_buf_clear = 1'b0;
    dphase_d    = w_addr_acc ? 1'b1 : (HREADY ? 1'b0 : dphase_q);

    if (w_pop) begin
      hwdata_d = w_buf_rdata;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          rem_d   = len_words;
          err_d   = 1'b0;
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        if (w_misaligned) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else if (rem_q == '0) begin
          state_d = S_FIN;
        end else begin
          chunk4_d    = w_chunk4;
          hburst_d    = w_chunk4 ? HBURST_INCR4 : HBURST_SINGLE;
          haddr_d     = src_q;
          htrans_d    = HTRANS_NONSEQ;
          hwrite_d    = 1'b0;
          abeat_d     = 2'd0;
          w_buf_clear = 1'b1;
          state_d     = S_RD;
        end
      end
      S_RD, S_WR: begin
        if (w_data_err) begin
          htrans_d = HTRANS_IDLE;
          state_d  = S_ABORT;
        end else if (w_addr_acc) begin
          if (w_last_beat) begin
            htrans_d = HTRANS_IDLE;
            state_d  = (state_q == S_RD) ? S_RD_END : S_WR_END;
          end else begin
            htrans_d = HTRANS_SEQ;
            haddr_d  = haddr_q + 32'd4;
            abeat_d  = abeat_q + 2'd1;
          end
        end
      end
      S_RD_END: begin
        if (w_data_err) begin
          htrans_d = HTRANS_IDLE;
          state_d  = S_ABORT;
        end else if (w_data_ok) begin
          haddr_d  = dst_q;
          htrans_d = HTRANS_NONSEQ;
          hwrite_d = 1'b1;
          abeat_d  = 2'd0;
          state_d  = S_WR;
        end
      end
      S_WR_END: begin
        if (w_data_err) begin
          htrans_d = HTRANS_IDLE;
          state_d  = S_ABORT;
        end else if (w_data_ok) begin
          src_d    = src_q + w_step;
          dst_d    = dst_q + w_step;
          rem_d    = rem_q - (chunk4_q ? LEN_W'(4) : LEN_W'(1));
          hwrite_d = 1'b0;
          state_d  = S_CHK;
        end
      end
      S_ABORT: begin
        htrans_d = HTRANS_IDLE;
        if (HREADY) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_FIN);
  assign err    = err_q;
  assign HADDR  = haddr_q;
  assign HTRANS = htrans_q;
  assign HWRITE = hwrite_q;
  assign HSIZE  = HSIZE_WORD;
  assign HBURST = hburst_q;
  assign HWDATA = hwdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_dma_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ahb_dma_master                                                    |
// | Directed bench for ahb_dma_master with a behavioural AHB memory.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ahb_dma_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len_words = '0;
  logic        busy, done, err;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic        HWRITE, HREADY;
  logic [2:0]  HSIZE, HBURST;

  ahb_dma_master #(.LEN_W(16), .BUF_DEPTH(4)) dut (
    .HCLK(clk), .HRESET(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len_words(len_words), .busy(busy), .done(done), .err(err), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural AHB memory slave (2KB, byte i = i[7:0]) ----
  logic [31:0] mem [512];
  logic        dp_valid, dp_write;
  logic [31:0] dp_addr;
  int          ws_left, er_left;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  logic [31:0] err_addr   = 32'hFFFF_FFFF;

  assign HREADY = (ws_left == 0) && (er_left != 2);
  assign HRESP  = (er_left != 0) ? 2'b01 : 2'b00;
  assign HRDATA = (dp_valid && !dp_write) ? mem[dp_addr[10:2]] : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) begin
        mem[i] <= {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      end
      dp_valid <= 1'b0; dp_write <= 1'b0; dp_addr <= '0;
      ws_left <= 0; er_left <= 0;
    end else begin
      if (ws_left > 0) ws_left <= ws_left - 1;
      if (er_left > 0) er_left <= er_left - 1;
      if (HREADY) begin
        if (dp_valid && dp_write && er_left == 0) mem[dp_addr[10:2]] <= HWDATA;
        dp_valid <= HTRANS[1];
        dp_addr  <= HADDR;
        dp_write <= HWRITE;
        if (HTRANS[1] && !HWRITE && HADDR == stall_addr) ws_left <= 2;
        if (HTRANS[1] &&  HWRITE && HADDR == err_addr)   er_left <= 2;
      end
    end
  end

  // ---------------- bus monitor ----------------
  int          cyc = 0;
  int          n_phase = 0, n_incr4 = 0, n_proto = 0;
  logic [31:0] last_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (HTRANS[1] && HREADY) begin
        n_phase <= n_phase + 1;
        if (HBURST == 3'b011) n_incr4 <= n_incr4 + 1;
        if (HTRANS == 2'b11 && HADDR != last_addr + 32'd4) n_proto <= n_proto + 1;
        last_addr <= HADDR;
      end
      if (HTRANS == 2'b01 || HSIZE != 3'b010) n_proto <= n_proto + 1;
    end
  end

  // ---------------- checking helpers ----------------
  int n_cmp = 0, n_fail = 0;
  int t0 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem[a[10:2]];
  endfunction

  task automatic do_reset();
    start = 1'b0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    @(negedge clk);
    src_addr = s; dst_addr = d; len_words = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(output int lat, output logic e);
    int guard = 0;
    while (done !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (done !== 1'b1) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: got no done, expected done within 2000 cycles");
      lat = -1; e = 1'bx;
    end else begin
      lat = cyc - t0 + 1;
      e   = err;
    end
  endtask

  typedef struct {
    logic [31:0] src, dst;
    logic [15:0] len;
    logic        exp_err;
    int          exp_lat, exp_ph, exp_i4;
    logic [31:0] a0, w0, a1, w1;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int   lat, ph0, i40, guard;
    logic e;

    vecs[0] = '{32'h000, 32'h100, 16'd6, 1'b0, 23, 12, 8, 32'h100, 32'h00010203, 32'h114, 32'h14151617};
    vecs[1] = '{32'h3F8, 32'h200, 16'd4, 1'b0, 22,  8, 0, 32'h200, 32'hF8F9FAFB, 32'h20C, 32'h04050607};
    vecs[2] = '{32'h002, 32'h100, 16'd3, 1'b1,  2,  0, 0, 32'h100, 32'h00010203, 32'h104, 32'h04050607};
    vecs[3] = '{32'h010, 32'h300, 16'd0, 1'b0,  2,  0, 0, 32'h300, 32'h00010203, 32'h304, 32'h04050607};
    vecs[4] = '{32'h000, 32'h101, 16'd2, 1'b1,  2,  0, 0, 32'h100, 32'h00010203, 32'h104, 32'h04050607};
    vecs[5] = '{32'h040, 32'h3F4, 16'd4, 1'b0, 22,  8, 0, 32'h3F4, 32'h40414243, 32'h400, 32'h4C4D4E4F};
    vecs[6] = '{32'h020, 32'h3F0, 16'd4, 1'b0, 13,  8, 8, 32'h3F0, 32'h20212223, 32'h3FC, 32'h2C2D2E2F};
    vecs[7] = '{32'h080, 32'h184, 16'd5, 1'b0, 18, 10, 8, 32'h184, 32'h80818283, 32'h194, 32'h90919293};

    // Reset values
    do_reset();
    check("reset_outputs", {busy, done, err, HTRANS, HWRITE, HBURST, HADDR, HWDATA}, 64'h0);
    check("reset_hsize", {61'h0, HSIZE}, 64'h2);

    // Table-driven copies
    for (int v = 0; v < 8; v++) begin
      do_reset();
      ph0 = n_phase; i40 = n_incr4;
      start_copy(vecs[v].src, vecs[v].dst, vecs[v].len);
      wait_done(lat, e);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d_err", v), {63'h0, e}, {63'h0, vecs[v].exp_err});
      check($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
      check($sformatf("v%0d_phases", v), 64'(n_phase - ph0), 64'(vecs[v].exp_ph));
      check($sformatf("v%0d_incr4", v), 64'(n_incr4 - i40), 64'(vecs[v].exp_i4));
      check($sformatf("v%0d_word0", v), {32'h0, rd_mem(vecs[v].a0)}, {32'h0, vecs[v].w0});
      check($sformatf("v%0d_word1", v), {32'h0, rd_mem(vecs[v].a1)}, {32'h0, vecs[v].w1});
    end

    // Wait states on read beat 2: beat 3 address must be held
    do_reset();
    stall_addr = 32'h8;
    start_copy(32'h000, 32'h180, 16'd4);
    guard = 0;
    while (HREADY !== 1'b0 && guard < 50) begin @(negedge clk); guard++; end
    check("stall1_hold", {HADDR, 30'h0, HTRANS}, {32'hC, 30'h0, 2'b11});
    @(negedge clk);
    check("stall2_hold", {HREADY, HADDR, HTRANS}, {1'b0, 32'hC, 2'b11});
    wait_done(lat, e);
    stall_addr = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    check("stall_latency", 64'(lat), 64'd15);
    check("stall_err", {63'h0, e}, 64'h0);
    check("stall_word0", {32'h0, rd_mem(32'h180)}, {32'h0, 32'h00010203});
    check("stall_word2", {32'h0, rd_mem(32'h188)}, {32'h0, 32'h08090A0B});

    // ERROR response on write beat 1
    do_reset();
    err_addr = 32'h204;
    start_copy(32'h040, 32'h200, 16'd4);
    guard = 0;
    while (HRESP === 2'b00 && guard < 50) begin @(negedge clk); guard++; end
    check("error_first_cycle", {62'h0, HREADY, HRESP[0]}, 64'h1);
    @(negedge clk);
    check("error_htrans_idle", {62'h0, HTRANS}, 64'h0);
    wait_done(lat, e);
    err_addr = 32'hFFFF_FFFF;
    check("error_err", {63'h0, e}, 64'h1);
    repeat (3) @(negedge clk);
    check("error_err_held", {62'h0, err, busy}, 64'h2);
    check("error_word0", {32'h0, rd_mem(32'h200)}, {32'h0, 32'h40414243});
    check("error_word1", {32'h0, rd_mem(32'h204)}, {32'h0, 32'h04050607});
    check("error_word2", {32'h0, rd_mem(32'h208)}, {32'h0, 32'h08090A0B});

    // start while busy and start coincident with done are both dropped
    do_reset();
    start_copy(32'h040, 32'h300, 16'd4);
    repeat (2) @(negedge clk);
    src_addr = 32'h080; dst_addr = 32'h390; len_words = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, e);
    check("busy_start_latency", 64'(lat), 64'd13);
    src_addr = 32'h000; dst_addr = 32'h3A0; len_words = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_start_dropped", {63'h0, busy}, 64'h0);
    repeat (8) @(negedge clk);
    check("busy_start_word", {32'h0, rd_mem(32'h300)}, {32'h0, 32'h40414243});
    check("busy_start_untouched", {32'h0, rd_mem(32'h390)}, {32'h0, 32'h90919293});
    check("done_start_untouched", {32'h0, rd_mem(32'h3A0)}, {32'h0, 32'hA0A1A2A3});

    // HRESET in the middle of a burst
    do_reset();
    start_copy(32'h000, 32'h100, 16'd4);
    guard = 0;
    while (HTRANS !== 2'b11 && guard < 50) begin @(negedge clk); guard++; end
    #2 rst = 1'b1;
    #1;
    check("midreset_outputs", {busy, done, err, HTRANS, HWRITE, HBURST, HADDR, HWDATA}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    guard = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || HTRANS != 2'b00 || busy) guard++;
    end
    check("midreset_quiet", 64'(guard), 64'h0);

    check("protocol", 64'(n_proto), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
